ssit_updater: RTL and testbench

Store Set ID Table (SSIT) plus a violation-driven update engine; sits directly upstream of the store set tracker (SST) and is its only client.
- Memory-ordering violations (load/store PC-hash indices) are buffered in a small FIFO and resolved one at a time with store-set merge rules.
- Each resolution requests a fresh SSID from the SST (new_SSID_valid) or touches a reused one (touch_SSID_valid).
- Provides a registered lookup port for the front-end, and a bulk-clear for periodic store-set invalidation.

---
 rtl/ssit_updater_if.sv | 25 ++
 rtl/ssit_updater.sv | 163 ++++++++++++++++
 tb/tb_ssit_updater.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ssit_updater_if.sv
// Violation intake and SST-side handshake bundle for ssit_updater.
// slave: the SSIT update engine. master: violation source plus store set tracker.
interface ssit_updater_if #(
  parameter int unsigned INDEX_WIDTH = 8,
  parameter int unsigned SSID_WIDTH  = 6
);
  logic                   viol_valid;
  logic                   viol_ready;
  logic [INDEX_WIDTH-1:0] viol_load_index;
  logic [INDEX_WIDTH-1:0] viol_store_index;
  logic                   new_SSID_valid;
  logic [SSID_WIDTH-1:0]  new_SSID;
  logic                   touch_SSID_valid;
  logic [SSID_WIDTH-1:0]  touch_SSID;

  modport master (
    output viol_valid, viol_load_index, viol_store_index, new_SSID,
    input  viol_ready, new_SSID_valid, touch_SSID_valid, touch_SSID
  );

  modport slave (
    input  viol_valid, viol_load_index, viol_store_index, new_SSID,
    output viol_ready, new_SSID_valid, touch_SSID_valid, touch_SSID
  );
endinterface

// File: rtl/ssit_updater.sv
// Store Set ID Table with a violation FIFO and a store-set merge engine.
// Each buffered violation is resolved in one RESOLVE cycle, either allocating a
// fresh SSID from the SST or touching the surviving SSID of the merged sets.
module ssit_updater #(
  parameter int unsigned SSIT_ENTRIES     = 256,
  parameter int unsigned SSIT_INDEX_WIDTH = $clog2(SSIT_ENTRIES),
  parameter int unsigned STORE_SET_COUNT  = 64,
  parameter int unsigned SSID_WIDTH       = $clog2(STORE_SET_COUNT),
  parameter int unsigned VIOL_FIFO_DEPTH  = 4
) (
  input  logic                        CLK,
  input  logic                        nRST,
  ssit_updater_if.slave               viol,
  input  logic [SSIT_INDEX_WIDTH-1:0] lookup_index,
  output logic                        lookup_SSID_valid,
  output logic [SSID_WIDTH-1:0]       lookup_SSID,
  input  logic                        clear_req
);

  localparam int unsigned PTR_W = $clog2(VIOL_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RESOLVE, CLEAR} state_t;

  state_t state;

  logic                        ssit_valid [SSIT_ENTRIES];
  logic [SSID_WIDTH-1:0]       ssit_ssid  [SSIT_ENTRIES];

  logic [SSIT_INDEX_WIDTH-1:0] fifo_load  [VIOL_FIFO_DEPTH];
  logic [SSIT_INDEX_WIDTH-1:0] fifo_store [VIOL_FIFO_DEPTH];
  logic [PTR_W:0]              wr_ptr;
  logic [PTR_W:0]              rd_ptr;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        push;

  logic [SSIT_INDEX_WIDTH-1:0] head_l;
  logic [SSIT_INDEX_WIDTH-1:0] head_s;
  logic [SSIT_INDEX_WIDTH-1:0] work_l;
  logic [SSIT_INDEX_WIDTH-1:0] work_s;
  logic [SSID_WIDTH-1:0]       work_ssid;
  logic                        pick_new;
  logic [SSID_WIDTH-1:0]       pick_ssid;
  logic [SSID_WIDTH-1:0]       res_ssid;

  logic                        clear_pending;
  logic                        new_valid_q;
  logic                        touch_valid_q;
  logic [SSID_WIDTH-1:0]       touch_ssid_q;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push       = viol.viol_valid && !fifo_full;
  assign head_l     = fifo_load[rd_ptr[PTR_W-1:0]];
  assign head_s     = fifo_store[rd_ptr[PTR_W-1:0]];

  assign viol.viol_ready       = !fifo_full;
  assign viol.new_SSID_valid   = new_valid_q;
  assign viol.touch_SSID_valid = touch_valid_q;
  assign viol.touch_SSID       = touch_ssid_q;

  // RESOLVE writes the SST's allocation when no set existed, else the merge winner.
  assign res_ssid = new_valid_q ? viol.new_SSID : work_ssid;

  // FIFO write pointer.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are meaningless while the pointers say empty.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_load[wr_ptr[PTR_W-1:0]]  <= viol.viol_load_index;
      fifo_store[wr_ptr[PTR_W-1:0]] <= viol.viol_store_index;
    end
  end

  // Merge decision for the FIFO head, made while popping so the RESOLVE-cycle
  // strobes can be registered. The SSIT cannot change between the pop and
  // RESOLVE, so this equals deciding on the RESOLVE-cycle contents.
  always_comb begin
    pick_new  = !ssit_valid[head_l] && !ssit_valid[head_s];
    pick_ssid = ssit_ssid[head_s];
    if (ssit_valid[head_l] && ssit_valid[head_s]) begin
      pick_ssid = (ssit_ssid[head_l] < ssit_ssid[head_s]) ? ssit_ssid[head_l]
                                                          : ssit_ssid[head_s];
    end else if (ssit_valid[head_l]) begin
      pick_ssid = ssit_ssid[head_l];
    end
  end

  // Control FSM, FIFO pop, SSIT updates and SST strobes.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      work_l        <= '0;
      work_s        <= '0;
      work_ssid     <= '0;
      clear_pending <= 1'b0;
      new_valid_q   <= 1'b0;
      touch_valid_q <= 1'b0;
      touch_ssid_q  <= '0;
      ssit_valid    <= '{default: 1'b0};
      ssit_ssid     <= '{default: '0};
    end else begin
      new_valid_q   <= 1'b0;
      touch_valid_q <= 1'b0;
      if (clear_req) begin
        clear_pending <= 1'b1;
      end else if (state == CLEAR) begin
        clear_pending <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (clear_pending) begin
            state <= CLEAR;
          end else if (!fifo_empty) begin
            rd_ptr        <= rd_ptr + 1'b1;
            work_l        <= head_l;
            work_s        <= head_s;
            work_ssid     <= pick_ssid;
            new_valid_q   <= pick_new;
            touch_valid_q <= !pick_new;
            if (!pick_new) begin
              touch_ssid_q <= pick_ssid;
            end
            state <= RESOLVE;
          end
        end
        RESOLVE: begin
          ssit_valid[work_l] <= 1'b1;
          ssit_valid[work_s] <= 1'b1;
          ssit_ssid[work_l]  <= res_ssid;
          ssit_ssid[work_s]  <= res_ssid;
          state              <= IDLE;
        end
        CLEAR: begin
          ssit_valid <= '{default: 1'b0};
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered front-end lookup; same-cycle writes show up on the next lookup.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lookup_SSID_valid <= 1'b0;
      lookup_SSID       <= '0;
    end else begin
      lookup_SSID_valid <= ssit_valid[lookup_index];
      lookup_SSID       <= ssit_ssid[lookup_index];
    end
  end

endmodule

// File: tb/tb_ssit_updater.sv
// Scoreboard bench for ssit_updater: a table-level SSIT model predicts every
// SST strobe and every lookup result; monitors compare as the DUT produces them.
module tb_ssit_updater;
  localparam int unsigned IW = 8;
  localparam int unsigned SW = 6;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [IW-1:0] lookup_index;
  logic          lookup_SSID_valid;
  logic [SW-1:0] lookup_SSID;
  logic          clear_req;

  ssit_updater_if #(.INDEX_WIDTH(IW), .SSID_WIDTH(SW)) bus ();

  ssit_updater #(
    .SSIT_ENTRIES(256),
    .STORE_SET_COUNT(64),
    .VIOL_FIFO_DEPTH(4)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .viol(bus),
    .lookup_index(lookup_index),
    .lookup_SSID_valid(lookup_SSID_valid),
    .lookup_SSID(lookup_SSID),
    .clear_req(clear_req)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // SST stand-in: hands out a fixed permutation of SSIDs, advancing on consume.
  function automatic logic [SW-1:0] sst_id(input int unsigned n);
    return SW'((n * 37) % 64);
  endfunction
  int unsigned alloc_cnt = 0;
  assign bus.new_SSID = sst_id(alloc_cnt);
  always @(posedge CLK) if (bus.new_SSID_valid) alloc_cnt <= alloc_cnt + 1;

  // Reference table and expectation queues.
  bit            m_valid [256];
  logic [SW-1:0] m_ssid  [256];
  int unsigned   m_alloc = 0;

  typedef struct {bit is_new; logic [SW-1:0] ssid;} ev_t;
  typedef struct {bit v; logic [SW-1:0] s; int unsigned cyc; logic [IW-1:0] idx;} lk_t;
  ev_t ev_q[$];
  lk_t lk_q[$];
  int unsigned ev_cycles[$];
  int pushed_cnt  = 0;
  int events_seen = 0;
  bit ready_low_seen = 0;

  function automatic void chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endfunction

  function automatic void model_viol(input logic [IW-1:0] l, input logic [IW-1:0] s);
    ev_t e;
    e.is_new = !m_valid[l] && !m_valid[s];
    if (e.is_new) begin
      e.ssid = sst_id(m_alloc);
      m_alloc++;
    end else if (m_valid[l] && m_valid[s]) begin
      e.ssid = (m_ssid[l] <= m_ssid[s]) ? m_ssid[l] : m_ssid[s];
    end else begin
      e.ssid = m_valid[l] ? m_ssid[l] : m_ssid[s];
    end
    m_valid[l] = 1'b1; m_valid[s] = 1'b1;
    m_ssid[l]  = e.ssid; m_ssid[s] = e.ssid;
    ev_q.push_back(e);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_ssid[i]  = '0;
    end
  endfunction

  // Monitor: SST strobes, back-pressure sanity, lookup results.
  ev_t mon_e;
  lk_t mon_l;
  bit  mon_ok;
  always @(negedge CLK) begin
    if (nRST) begin
      if (bus.new_SSID_valid || bus.touch_SSID_valid) begin
        ev_cycles.push_back(cyc);
        events_seen++;
        total++;
        if (ev_q.size() == 0) begin
          bad++;
          $display("FAIL sst_event: got new=%0d touch=%0d, required no strobe",
                   bus.new_SSID_valid, bus.touch_SSID_valid);
        end else begin
          mon_e = ev_q.pop_front();
          if (mon_e.is_new) mon_ok = bus.new_SSID_valid && !bus.touch_SSID_valid;
          else mon_ok = bus.touch_SSID_valid && !bus.new_SSID_valid &&
                        (bus.touch_SSID == mon_e.ssid);
          if (!mon_ok) begin
            bad++;
            $display("FAIL sst_event: got new=%0d touch=%0d touch_SSID=%0d, required new=%0d ssid=%0d",
                     bus.new_SSID_valid, bus.touch_SSID_valid, bus.touch_SSID,
                     mon_e.is_new, mon_e.ssid);
          end
        end
      end
      if (!bus.viol_ready) begin
        ready_low_seen = 1'b1;
        total++;
        if (pushed_cnt - events_seen < 4) begin
          bad++;
          $display("FAIL ready_early: viol_ready=0 with %0d outstanding, required >=4",
                   pushed_cnt - events_seen);
        end
      end
      if (lk_q.size() != 0 && lk_q[0].cyc + 1 == cyc) begin
        mon_l = lk_q.pop_front();
        total++;
        if (lookup_SSID_valid != mon_l.v || lookup_SSID != mon_l.s) begin
          bad++;
          $display("FAIL lookup[%0h]: got valid=%0d ssid=%0d, required valid=%0d ssid=%0d",
                   mon_l.idx, lookup_SSID_valid, lookup_SSID, mon_l.v, mon_l.s);
        end
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge CLK);
  endtask

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic push(input logic [IW-1:0] l, input logic [IW-1:0] s, input bit do_model);
    int unsigned w = 0;
    bus.viol_valid = 1'b1;
    bus.viol_load_index = l;
    bus.viol_store_index = s;
    while (!bus.viol_ready && w < 200) begin
      @(negedge CLK);
      w++;
    end
    if (!bus.viol_ready) begin
      total++; bad++;
      $display("FAIL push_wait: viol_ready=0 after %0d cycles, required 1", w);
      bus.viol_valid = 1'b0;
    end else begin
      pushed_cnt++;
      if (do_model) model_viol(l, s);
      @(negedge CLK);
      bus.viol_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int unsigned w = 0;
    while (ev_q.size() != 0 && w < 500) begin
      @(negedge CLK);
      w++;
    end
    chk("drain_pending", ev_q.size(), 0);
    ev_q.delete();
    tick(3);
  endtask

  task automatic look(input logic [IW-1:0] idx);
    lk_t e;
    lookup_index = idx;
    e.v = m_valid[idx]; e.s = m_ssid[idx]; e.cyc = cyc; e.idx = idx;
    lk_q.push_back(e);
    @(negedge CLK);
  endtask

  task automatic look_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) look(IW'(i));
    tick(2);
  endtask

  task automatic clear_pulse();
    clear_req = 1'b1;
    @(negedge CLK);
    clear_req = 1'b0;
    model_clear();
    tick(4);
  endtask

  function automatic logic [IW-1:0] rnd_idx();
    if ($urandom_range(0, 3) == 0) return IW'($urandom_range(240, 255));
    return IW'($urandom_range(0, 31));
  endfunction

  initial begin
    nRST = 1'b0;
    clear_req = 1'b0;
    lookup_index = '0;
    bus.viol_valid = 1'b0;
    bus.viol_load_index = '0;
    bus.viol_store_index = '0;
    model_reset();
    tick(3);
    chk("rst_viol_ready", bus.viol_ready, 1);
    chk("rst_lookup_valid", lookup_SSID_valid, 0);
    chk("rst_lookup_ssid", lookup_SSID, 0);
    chk("rst_new_valid", bus.new_SSID_valid, 0);
    chk("rst_touch_valid", bus.touch_SSID_valid, 0);
    chk("rst_touch_ssid", bus.touch_SSID, 0);
    nRST = 1'b1;
    tick(2);

    // Fresh set, then each merge flavour including L==S and index extremes.
    push(8'h10, 8'h20, 1);
    drain();
    look(8'h10); look(8'h20); tick(2);
    push(8'h10, 8'h30, 1);
    push(8'h50, 8'h60, 1);
    push(8'h70, 8'h70, 1);
    push(8'h50, 8'h70, 1);
    push(8'h70, 8'h10, 1);
    push(8'h80, 8'h20, 1);
    push(8'hFF, 8'h00, 1);
    push(8'h44, 8'h44, 1);
    push(8'h44, 8'h44, 1);
    drain();
    look(8'h10); look(8'h20); look(8'h30); look(8'h44); look(8'h50);
    look(8'h60); look(8'h70); look(8'h80); look(8'hFF); look(8'h00);
    tick(2);

    // Quiescent clear: valid bits drop, SSIDs stay.
    clear_pulse();
    look(8'h10); look(8'h44); look(8'hFF); tick(2);

    // Clear arriving in the RESOLVE cycle of the first of three violations.
    push(8'h21, 8'h22, 1);
    chk("ready_v2", bus.viol_ready, 1);
    bus.viol_valid = 1'b1; bus.viol_load_index = 8'h23; bus.viol_store_index = 8'h24;
    pushed_cnt++;
    @(negedge CLK);
    chk("resolve_latency", bus.new_SSID_valid || bus.touch_SSID_valid, 1);
    chk("ready_v3", bus.viol_ready, 1);
    clear_req = 1'b1;
    bus.viol_load_index = 8'h24; bus.viol_store_index = 8'h25;
    pushed_cnt++;
    model_clear();
    model_viol(8'h23, 8'h24);
    model_viol(8'h24, 8'h25);
    @(negedge CLK);
    clear_req = 1'b0;
    bus.viol_valid = 1'b0;
    drain();
    look_range(8'h20, 8'h26);

    // Back-to-back burst: fills the FIFO, must resolve one per two cycles.
    ev_cycles.delete();
    ready_low_seen = 1'b0;
    for (int i = 0; i < 12; i++)
      push(IW'($urandom_range(0, 15)), IW'($urandom_range(0, 15)), 1);
    drain();
    chk("burst_backpressure", ready_low_seen, 1);
    chk("burst_event_count", ev_cycles.size(), 12);
    for (int i = 1; i < ev_cycles.size(); i++)
      chk("burst_spacing", ev_cycles[i] - ev_cycles[i-1], 2);
    look_range(0, 15);

    // Randomized traffic with gaps; a quiescent clear between rounds.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 15; i++) begin
        push(rnd_idx(), rnd_idx(), 1);
        tick($urandom_range(0, 3));
      end
      drain();
      look_range(0, 31);
      look_range(240, 255);
      if (r == 1) clear_pulse();
    end

    // Asynchronous reset with a violation in flight.
    push(8'h33, 8'h34, 1);
    drain();
    lookup_index = 8'h33;
    tick(1);
    chk("pre_reset_lookup_valid", lookup_SSID_valid, 1);
    push(8'h55, 8'h56, 0);
    #2 nRST = 1'b0;
    #1;
    chk("async_rst_lookup_valid", lookup_SSID_valid, 0);
    chk("async_rst_lookup_ssid", lookup_SSID, 0);
    chk("async_rst_ready", bus.viol_ready, 1);
    chk("async_rst_new", bus.new_SSID_valid, 0);
    chk("async_rst_touch", bus.touch_SSID_valid, 0);
    model_reset();
    pushed_cnt = 0;
    events_seen = 0;
    tick(2);
    nRST = 1'b1;
    tick(6);
    look(8'h33); look(8'h55); look(8'h56); tick(2);
    push(8'h55, 8'h56, 1);
    drain();
    look(8'h55); look(8'h56); look(8'h33); tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end
endmodule
